// File: rtl/pid_cntrl_pipe.sv
// Pipelined PID balance controller: saturated pitch error, anti-windup integrator,
// three registered stages with an output strobe, and a soft-start ramp timer.
module pid_cntrl_pipe #(
  parameter int ERR_W    = 10,
  parameter int INT_W    = 18,
  parameter int OUT_W    = 12,
  parameter int P_COEFF  = 12,
  parameter int I_SHIFT  = 6,
  parameter int D_SHIFT  = 6,
  parameter int SS_W     = 27,
  parameter int FAST_SIM = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld,
  input  logic [15:0]      ptch,
  input  logic [15:0]      ptch_rt,
  input  logic             pwr_up,
  input  logic             rider_off,
  input  logic             hold,
  output logic [7:0]       ss_tmr,
  output logic [OUT_W-1:0] PID_cntrl,
  output logic             cntrl_vld,
  output logic             int_sat
);

  localparam int I_SH  = (FAST_SIM != 0) ? 1 : I_SHIFT;
  localparam int PW    = ERR_W + 5;
  localparam int SUM_W = OUT_W + 5;

  localparam logic signed [15:0]       ERR_MAX = 16'(2**(ERR_W-1) - 1);
  localparam logic signed [15:0]       ERR_MIN = 16'(-(2**(ERR_W-1)));
  localparam logic signed [INT_W-1:0]  INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic signed [INT_W-1:0]  INT_MIN = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0]  OUT_MAX = SUM_W'(2**(OUT_W-1) - 1);
  localparam logic signed [SUM_W-1:0]  OUT_MIN = SUM_W'(-(2**(OUT_W-1)));
  localparam logic [SS_W-1:0]          SS_MAX  = {SS_W{1'b1}};
  localparam logic [SS_W-1:0]          SS_INC  = SS_W'((FAST_SIM != 0) ? 256 : 1);

  logic signed [ERR_W-1:0] err_s, err_q, err_d;
  logic signed [15:0]      rt_q, rt_d;
  logic                    v1_q, v1_d, v2_q, v2_d;
  logic signed [INT_W-1:0] integ_q, integ_d;
  logic [INT_W:0]          int_sum_s;
  logic signed [PW-1:0]    p_q, p_d;
  logic signed [INT_W-1:0] i_q, i_d;
  logic signed [15:0]      d_q, d_d;
  logic signed [SUM_W-1:0] sum_s;
  logic [OUT_W-1:0]        pid_cntrl_q, pid_cntrl_d;
  logic                    cntrl_vld_q, cntrl_vld_d;
  logic                    int_sat_q, int_sat_d;
  logic [SS_W-1:0]         ss_q, ss_d;

  // Stage 1: error clamp, sample capture and saturating integrator.
  always_comb begin
    err_d     = err_q;
    rt_d      = rt_q;
    v1_d      = vld;
    integ_d   = integ_q;
    int_sum_s = {integ_q[INT_W-1], integ_q} +
                {{(INT_W+1-ERR_W){err_s[ERR_W-1]}}, err_s};
    if ($signed(ptch) > ERR_MAX) begin
      err_s = ERR_MAX[ERR_W-1:0];
    end else if ($signed(ptch) < ERR_MIN) begin
      err_s = ERR_MIN[ERR_W-1:0];
    end else begin
      err_s = ptch[ERR_W-1:0];
    end
    if (vld) begin
      err_d = err_s;
      rt_d  = ptch_rt;
    end else begin
      err_d = err_q;
    end
    if (rider_off) begin
      integ_d = '0;
    end else if (vld && !hold) begin
      // Two top bits disagree only on overflow; the true sign picks the rail.
      if (int_sum_s[INT_W] != int_sum_s[INT_W-1]) begin
        integ_d = int_sum_s[INT_W] ? INT_MIN : INT_MAX;
      end else begin
        integ_d = int_sum_s[INT_W-1:0];
      end
    end else begin
      integ_d = integ_q;
    end
    int_sat_d = (integ_q == INT_MAX) || (integ_q == INT_MIN);
  end

  // Stages 2 and 3: term formation, summation with output clamp, soft-start ramp.
  always_comb begin
    v2_d        = v1_q;
    p_d         = $signed({{5{err_q[ERR_W-1]}}, err_q}) * $signed(PW'(P_COEFF));
    i_d         = integ_q >>> I_SH;
    d_d         = -(rt_q >>> D_SHIFT);
    sum_s       = SUM_W'(p_q) + SUM_W'(i_q) + SUM_W'(d_q);
    cntrl_vld_d = v2_q;
    pid_cntrl_d = pid_cntrl_q;
    if (v2_q) begin
      if (sum_s > OUT_MAX) begin
        pid_cntrl_d = OUT_MAX[OUT_W-1:0];
      end else if (sum_s < OUT_MIN) begin
        pid_cntrl_d = OUT_MIN[OUT_W-1:0];
      end else begin
        pid_cntrl_d = sum_s[OUT_W-1:0];
      end
    end else begin
      pid_cntrl_d = pid_cntrl_q;
    end
    if (!pwr_up) begin
      ss_d = '0;
    end else if (ss_q > (SS_MAX - SS_INC)) begin
      ss_d = SS_MAX;
    end else begin
      ss_d = ss_q + SS_INC;
    end
  end

  // State registers; reset discards any samples in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q       <= '0;
      rt_q        <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      integ_q     <= '0;
      p_q         <= '0;
      i_q         <= '0;
      d_q         <= '0;
      pid_cntrl_q <= '0;
      cntrl_vld_q <= 1'b0;
      int_sat_q   <= 1'b0;
      ss_q        <= '0;
    end else begin
      err_q       <= err_d;
      rt_q        <= rt_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      integ_q     <= integ_d;
      p_q         <= p_d;
      i_q         <= i_d;
      d_q         <= d_d;
      pid_cntrl_q <= pid_cntrl_d;
      cntrl_vld_q <= cntrl_vld_d;
      int_sat_q   <= int_sat_d;
      ss_q        <= ss_d;
    end
  end

  assign ss_tmr    = ss_q[SS_W-1 -: 8];
  assign PID_cntrl = pid_cntrl_q;
  assign cntrl_vld = cntrl_vld_q;
  assign int_sat   = int_sat_q;

endmodule

// File: tb/tb_pid_cntrl_pipe.sv
// Randomized self-checking bench for pid_cntrl_pipe against an arithmetic reference model.
module tb_pid_cntrl_pipe;

  localparam int SS_W   = 12;
  localparam int SS_MAX = (1 << SS_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld, pwr_up, rider_off, hold;
  logic [15:0] ptch, ptch_rt;
  logic [7:0]  ss_tmr;
  logic [11:0] PID_cntrl;
  logic        cntrl_vld, int_sat;

  int n_err = 0;
  int n_chk = 0;

  // reference model state
  int m_integ, m_out, m_cyc, m_ss;
  bit m_vld, m_sat;
  int q_val[$];
  int q_due[$];

  pid_cntrl_pipe #(.SS_W(SS_W)) dut (
    .clk(clk), .rst(rst), .vld(vld), .ptch(ptch), .ptch_rt(ptch_rt),
    .pwr_up(pwr_up), .rider_off(rider_off), .hold(hold), .ss_tmr(ss_tmr),
    .PID_cntrl(PID_cntrl), .cntrl_vld(cntrl_vld), .int_sat(int_sat)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic model_reset();
    m_integ = 0; m_out = 0; m_cyc = 0; m_ss = 0; m_vld = 0; m_sat = 0;
    q_val.delete();
    q_due.delete();
  endtask

  // One rising edge of the controller as the spec describes it.
  task automatic model_edge();
    int e, pv, rv;
    m_cyc++;
    m_sat = (m_integ == 131071) || (m_integ == -131072);
    m_vld = 0;
    if (q_due.size() > 0 && q_due[0] == m_cyc) begin
      m_vld = 1;
      m_out = q_val.pop_front();
      void'(q_due.pop_front());
    end
    pv = $signed(ptch);
    rv = $signed(ptch_rt);
    e  = clamp(pv, -512, 511);
    if (rider_off) m_integ = 0;
    else if (vld && !hold) m_integ = clamp(m_integ + e, -131072, 131071);
    if (vld) begin
      q_val.push_back(clamp(e * 12 + (m_integ >>> 6) - (rv >>> 6), -2048, 2047));
      q_due.push_back(m_cyc + 2);
    end
    m_ss = pwr_up ? ((m_ss + 1 > SS_MAX) ? SS_MAX : m_ss + 1) : 0;
  endtask

  task automatic check_all();
    check_val("cntrl_vld", int'(cntrl_vld), int'(m_vld));
    check_val("PID_cntrl", int'($signed(PID_cntrl)), m_out);
    check_val("int_sat", int'(int_sat), int'(m_sat));
    check_val("ss_tmr", int'(ss_tmr), m_ss >> (SS_W - 8));
  endtask

  task automatic step(input logic v, input logic [15:0] p, input logic [15:0] r,
                      input logic pu, input logic ro, input logic h);
    vld = v; ptch = p; ptch_rt = r; pwr_up = pu; rider_off = ro; hold = h;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; ptch = 16'h0000; ptch_rt = 16'h0000;
    pwr_up = 1'b0; rider_off = 1'b0; hold = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // single small sample: strobe exactly two edges later
    step(1'b1, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    check_val("t1_vld_early", int'(cntrl_vld), 0);
    step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    check_val("t1_vld", int'(cntrl_vld), 1);
    check_val("t1_pid", int'(PID_cntrl), 32'h0C0);
    idle(1);
    check_val("t1_vld_once", int'(cntrl_vld), 0);

    // output clamping and derivative term
    step(1'b1, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    idle(2);
    check_val("t2_pos_sat", int'(PID_cntrl), 32'h7FF);
    step(1'b1, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0);
    idle(2);
    check_val("t2_neg_sat", int'(PID_cntrl), 32'h800);
    step(1'b1, 16'h0000, 16'h0400, 1'b1, 1'b0, 1'b0);
    idle(2);
    check_val("t2_d_term", int'(PID_cntrl), 32'hFF0);

    // integrator anti-windup
    for (int k = 0; k < 260; k++) step(1'b1, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    check_val("t3_int_sat", int'(int_sat), 1);

    // rider_off clears, hold freezes
    step(1'b1, 16'h7FFF, 16'h0000, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    check_val("t4_sat_clear", int'(int_sat), 0);
    for (int k = 0; k < 5; k++) step(1'b1, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    idle(2);
    check_val("t4_hold_zero", int'($signed(PID_cntrl)), 0);

    // randomized operation
    for (int k = 0; k < 500; k++) begin
      logic [15:0] pv;
      pv = ($urandom_range(0, 1) == 0) ? 16'($urandom) : (16'($urandom_range(0, 2047)) - 16'd1024);
      step(1'($urandom_range(0, 3) != 0), pv, 16'($urandom),
           1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 7) == 0));
    end

    // reset in the middle of a stream
    for (int k = 0; k < 5; k++) step(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    model_reset();
    check_val("t6_pid_rst", int'(PID_cntrl), 0);
    check_val("t6_vld_rst", int'(cntrl_vld), 0);
    check_val("t6_sat_rst", int'(int_sat), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b0);
    check_val("t6_no_vld1", int'(cntrl_vld), 0);
    step(1'b1, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b0);
    check_val("t6_no_vld2", int'(cntrl_vld), 0);
    step(1'b1, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b0);
    check_val("t6_first_vld", int'(cntrl_vld), 1);
    check_val("t6_first_pid", int'(PID_cntrl), 384);
    idle(3);

    // soft-start ramp, clamp and clear
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    check_val("t5_ss_clear0", int'(ss_tmr), 0);
    for (int k = 0; k < SS_MAX + 10; k++) begin
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
      if (k == 15) check_val("t5_ss_first", int'(ss_tmr), 1);
    end
    check_val("t5_ss_clamp", int'(ss_tmr), 32'hFF);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    check_val("t5_ss_drop", int'(ss_tmr), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
